// File: rtl/alu_bin_to_bcd_pkg.sv
// Shared types and helpers for the binary-to-BCD converter.
// FSM encoding, nibble width, counter sizing and the digit-capacity check.
package alu_bin_to_bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  localparam int NIBBLE_W = 4;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  // True when DIGITS decimal digits can hold the largest WIDTH-bit magnitude.
  function automatic bit digits_fit(input int width, input int digits);
    longint unsigned p;
    longint unsigned maxv;
    p = 1;
    for (int i = 0; i < digits; i++) p = p * 10;
    maxv = (64'd1 << width) - 64'd1;
    return p > maxv;
  endfunction

endpackage

// File: rtl/alu_bin_to_bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD nibble that is 5 or more.
// Purely combinational, zero latency, no flow control.
module bcd_add3_digit
  import alu_bin_to_bcd_pkg::*;
(
  input  logic [NIBBLE_W-1:0] digit_i,
  output logic [NIBBLE_W-1:0] digit_o
);

  assign digit_o = (digit_i >= NIBBLE_W'(5)) ? digit_i + NIBBLE_W'(3) : digit_i;

endmodule

// File: rtl/alu_bin_to_bcd.sv
// Iterative shift-add-3 binary to BCD converter with sign and leading-zero blanking.
// Result and done pulse WIDTH+1 edges after the start edge; start is ignored while busy.
module alu_bin_to_bcd
  import alu_bin_to_bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 4
) (
  input  logic                         clk50MHz,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         signed_en,
  input  logic [WIDTH-1:0]             bin_in,
  output logic                         busy,
  output logic                         done,
  output logic                         neg,
  output logic [NIBBLE_W*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]            blank
);

  localparam int                BW        = NIBBLE_W * DIGITS;
  localparam int                CW        = cnt_width(WIDTH);
  localparam logic [CW-1:0]     CNT_LOAD  = CW'(WIDTH);
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

  if (!digits_fit(WIDTH, DIGITS)) begin : g_bad_params
    $error("alu_bin_to_bcd: DIGITS too small to hold 2^WIDTH-1");
  end

  state_t                state_q;
  logic [CW-1:0]         cnt_q;
  logic [BW+WIDTH-1:0]   sh_q;
  logic                  sign_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  neg_q;
  logic [BW-1:0]         bcd_q;
  logic [DIGITS-1:0]     blank_q;

  logic [WIDTH-1:0]      mag_d;
  logic [BW-1:0]         adj_bcd;
  logic [BW+WIDTH-1:0]   sh_d;
  logic [DIGITS-1:0]     blank_d;
  logic                  upper_zero;

  // Most negative input negates to itself, which is the correct unsigned magnitude.
  assign mag_d = (signed_en && bin_in[WIDTH-1]) ? (WIDTH'(0) - bin_in) : bin_in;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_add3_digit u_add3 (
      .digit_i (sh_q[WIDTH+NIBBLE_W*g +: NIBBLE_W]),
      .digit_o (adj_bcd[NIBBLE_W*g +: NIBBLE_W])
    );
  end

  assign sh_d = {adj_bcd[BW-2:0], sh_q[WIDTH-1:0], 1'b0};

  always_comb begin
    blank_d    = '0;
    upper_zero = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      upper_zero = upper_zero & (sh_q[WIDTH+NIBBLE_W*k +: NIBBLE_W] == '0);
      blank_d[k] = upper_zero;
    end
  end

  always_ff @(posedge clk50MHz) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      sign_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      neg_q   <= 1'b0;
      bcd_q   <= '0;
      blank_q <= BLANK_RST;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            sh_q    <= {BW'(0), mag_d};
            cnt_q   <= CNT_LOAD;
            sign_q  <= signed_en & bin_in[WIDTH-1];
            busy_q  <= 1'b1;
            state_q <= ST_CONV;
          end
        end
        ST_CONV: begin
          sh_q  <= sh_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= ST_FINISH;
        end
        ST_FINISH: begin
          bcd_q   <= sh_q[WIDTH +: BW];
          blank_q <= blank_d;
          neg_q   <= sign_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign neg     = neg_q;
  assign bcd_out = bcd_q;
  assign blank   = blank_q;

endmodule

// File: tb/tb_alu_bin_to_bcd.sv
// Directed and random checks of alu_bin_to_bcd against a decimal-arithmetic reference model.
module tb_alu_bin_to_bcd;

  logic        clk50MHz  = 1'b0;
  logic        rst       = 1'b0;
  logic        start     = 1'b0;
  logic        signed_en = 1'b0;
  logic [7:0]  bin_in    = 8'd0;
  logic        busy;
  logic        done;
  logic        neg;
  logic [15:0] bcd_out;
  logic [3:0]  blank;

  int          n_asserts  = 0;
  int          n_fail     = 0;
  int          cyc        = 0;
  int          done_count = 0;
  logic [15:0] prev_bcd   = 16'h0000;
  logic [7:0]  cap_v      = 8'd0;
  logic        cap_s      = 1'b0;

  alu_bin_to_bcd #(.WIDTH(8), .DIGITS(4)) dut (
    .clk50MHz  (clk50MHz),
    .rst       (rst),
    .start     (start),
    .signed_en (signed_en),
    .bin_in    (bin_in),
    .busy      (busy),
    .done      (done),
    .neg       (neg),
    .bcd_out   (bcd_out),
    .blank     (blank)
  );

  always #10 clk50MHz = ~clk50MHz;

  always @(posedge clk50MHz) cyc++;
  always @(negedge clk50MHz) if (done === 1'b1) done_count++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal digits of the magnitude; digit k blank iff magnitude < 10^k.
  task automatic model(input logic [7:0] v, input logic s,
                       output logic [15:0] bcd, output logic [3:0] bl, output logic ng);
    int mag;
    int p;
    mag = (s && v[7]) ? 256 - int'(v) : int'(v);
    p   = 1;
    bcd = '0;
    bl  = '0;
    for (int k = 0; k < 4; k++) begin
      bcd[4*k +: 4] = 4'((mag / p) % 10);
      bl[k]         = (k > 0) && (mag < p);
      p             = p * 10;
    end
    ng = s && v[7];
  endtask

  task automatic issue(input logic [7:0] v, input logic s);
    bin_in    = v;
    signed_en = s;
    start     = 1'b1;
    cap_v     = v;
    cap_s     = s;
  endtask

  // Called at a negedge with start already driven; returns at the done negedge.
  task automatic finish_conv(input string tag, input int inject_n, input logic [7:0] inj_v);
    logic [15:0] eb;
    logic [3:0]  ebl;
    logic        eng;
    int          lat;
    int          busy_cyc;
    bit          hold_ok;
    model(cap_v, cap_s, eb, ebl, eng);
    @(posedge clk50MHz);
    @(negedge clk50MHz);
    start    = 1'b0;
    lat      = 0;
    busy_cyc = 0;
    hold_ok  = 1'b1;
    while (done !== 1'b1 && lat < 20) begin
      if (busy === 1'b1) busy_cyc++;
      if (bcd_out !== prev_bcd) hold_ok = 1'b0;
      if (lat == inject_n) begin
        start     = 1'b1;
        bin_in    = inj_v;
        signed_en = 1'b0;
      end else if (lat == inject_n + 1) begin
        start = 1'b0;
      end
      @(negedge clk50MHz);
      lat++;
    end
    check($sformatf("%s latency", tag), 32'(lat), 32'd9);
    check($sformatf("%s busy cycles", tag), 32'(busy_cyc), 32'd9);
    check($sformatf("%s hold during conv", tag), 32'(hold_ok), 32'd1);
    check($sformatf("%s bcd_out", tag), 32'(bcd_out), 32'(eb));
    check($sformatf("%s blank", tag), 32'(blank), 32'(ebl));
    check($sformatf("%s neg", tag), 32'(neg), 32'(eng));
    check($sformatf("%s busy at done", tag), 32'(busy), 32'd0);
    prev_bcd = eb;
  endtask

  initial begin
    int n0;
    int c1;
    int c2;

    // Reset
    repeat (2) @(posedge clk50MHz);
    @(negedge clk50MHz);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset neg", 32'(neg), 32'd0);
    check("reset bcd_out", 32'(bcd_out), 32'h0000);
    check("reset blank", 32'(blank), 32'b1110);
    rst = 1'b1;

    // 255 unsigned, then check one-cycle done pulse
    @(negedge clk50MHz);
    issue(8'd255, 1'b0);
    finish_conv("t1_255", -1, 8'd0);
    check("t1 bcd const", 32'(bcd_out), 32'h0255);
    @(negedge clk50MHz);
    check("t1 done pulse width", 32'(done), 32'd0);

    // Signed values
    issue(8'hF6, 1'b1);
    finish_conv("t2_m10", -1, 8'd0);
    check("t2 m10 const", 32'({neg, blank, bcd_out}), 32'({1'b1, 4'b1100, 16'h0010}));
    @(negedge clk50MHz);
    issue(8'h80, 1'b1);
    finish_conv("t2_m128", -1, 8'd0);
    check("t2 m128 const", 32'({neg, bcd_out}), 32'({1'b1, 16'h0128}));

    // Zero with signed_en
    @(negedge clk50MHz);
    issue(8'd0, 1'b1);
    finish_conv("t3_zero", -1, 8'd0);
    check("t3 zero const", 32'({neg, blank, bcd_out}), 32'({1'b0, 4'b1110, 16'h0000}));

    // Start while busy is ignored
    @(negedge clk50MHz);
    n0 = done_count;
    issue(8'd42, 1'b0);
    finish_conv("t4_busy_start", 3, 8'd99);
    check("t4 bcd const", 32'(bcd_out), 32'h0042);
    repeat (12) @(negedge clk50MHz);
    check("t4 single done", 32'(done_count - n0), 32'd1);

    // Reset mid-conversion aborts without a done pulse
    n0 = done_count;
    issue(8'd200, 1'b0);
    @(posedge clk50MHz);
    @(negedge clk50MHz);
    start = 1'b0;
    repeat (4) @(negedge clk50MHz);
    rst = 1'b0;
    @(negedge clk50MHz);
    check("t5 abort busy", 32'(busy), 32'd0);
    check("t5 abort bcd_out", 32'(bcd_out), 32'h0000);
    check("t5 abort blank", 32'(blank), 32'b1110);
    check("t5 abort done", 32'(done), 32'd0);
    rst = 1'b1;
    repeat (12) @(negedge clk50MHz);
    check("t5 no done after abort", 32'(done_count - n0), 32'd0);
    prev_bcd = 16'h0000;
    issue(8'd99, 1'b0);
    finish_conv("t5_99", -1, 8'd0);
    check("t5 99 const", 32'({blank, bcd_out}), 32'({4'b1100, 16'h0099}));

    // Back-to-back: start in the done cycle
    @(negedge clk50MHz);
    issue(8'd7, 1'b0);
    finish_conv("t6_7", -1, 8'd0);
    c1 = cyc;
    issue(8'd150, 1'b0);
    finish_conv("t6_150", -1, 8'd0);
    c2 = cyc;
    check("t6 done spacing", 32'(c2 - c1), 32'd10);
    check("t6 bcd const", 32'(bcd_out), 32'h0150);

    // Random values, signed and unsigned
    for (int i = 0; i < 20; i++) begin
      @(negedge clk50MHz);
      issue(8'($urandom_range(255)), 1'($urandom_range(1)));
      finish_conv($sformatf("rand%0d", i), -1, 8'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
